// File: rtl/ll_rr_dequeue_pkg.sv
// Shared sizing for the round-robin dequeue block and its linked-list pointer manager.
package ll_rr_dequeue_pkg;

  localparam int DEF_NUM_ELEMS  = 4;
  localparam int DEF_NUM_LISTS  = 2;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_PTR_WIDTH  = $clog2(DEF_NUM_ELEMS);
  localparam int DEF_SEL_WIDTH  = $clog2(DEF_NUM_LISTS);

  // Wraps an index that overshot by less than one full lap back into 0..n-1.
  function automatic int rr_wrap(input int idx, input int n);
    return (idx >= n) ? (idx - n) : idx;
  endfunction

endpackage

// File: rtl/ll_rr_dequeue_rr_arbiter.sv
// Round-robin search: first requesting index after the last grant, wrapping modulo N.
module rr_arbiter
  import ll_rr_dequeue_pkg::*;
#(
  parameter int N     = DEF_NUM_LISTS,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] last_i,
  output logic             gnt_valid_o,
  output logic [IDX_W-1:0] gnt_idx_o
);

  int idx_c;

  // Scan last+1 .. last+N so the previously granted list is considered last.
  always_comb begin
    idx_c       = 0;
    gnt_valid_o = 1'b0;
    gnt_idx_o   = '0;
    for (int i = 1; i <= N; i++) begin
      idx_c = rr_wrap(int'(last_i) + i, N);
      if (!gnt_valid_o && req_i[idx_c[IDX_W-1:0]]) begin
        gnt_valid_o = 1'b1;
        gnt_idx_o   = IDX_W'(idx_c);
      end
    end
  end

endmodule

// File: rtl/ll_rr_dequeue.sv
// Shared-buffer egress stage: stores payloads at pointer-manager slots and
// drains the logical lists round-robin into a single output register.
module ll_rr_dequeue
  import ll_rr_dequeue_pkg::*;
#(
  parameter  int NUM_ELEMS  = DEF_NUM_ELEMS,
  parameter  int NUM_LISTS  = DEF_NUM_LISTS,
  parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
  localparam int PTR_WIDTH  = $clog2(NUM_ELEMS),
  localparam int SEL_WIDTH  = $clog2(NUM_LISTS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [SEL_WIDTH-1:0]  in_sel,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [SEL_WIDTH-1:0]  out_sel,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  ll_push,
  output logic                  ll_pop,
  output logic [SEL_WIDTH-1:0]  ll_push_sel,
  output logic [SEL_WIDTH-1:0]  ll_pop_sel,
  input  logic                  ll_full,
  input  logic [NUM_LISTS-1:0]  ll_empty,
  input  logic [PTR_WIDTH-1:0]  ll_free_ptr,
  input  logic [PTR_WIDTH-1:0]  ll_popped_head
);

  logic [DATA_WIDTH-1:0] data_mem_q [NUM_ELEMS];

  logic                  out_valid_q, out_valid_d;
  logic [SEL_WIDTH-1:0]  out_sel_q,   out_sel_d;
  logic [DATA_WIDTH-1:0] out_data_q,  out_data_d;
  logic [SEL_WIDTH-1:0]  rr_ptr_q,    rr_ptr_d;

  logic                  out_open;
  logic                  gnt_valid;
  logic [SEL_WIDTH-1:0]  gnt_idx;

  // Push is gated by reset through in_ready; a full buffer never pushes even if a pop frees a slot this cycle.
  assign in_ready    = rst_n & ~ll_full;
  assign ll_push     = in_valid & in_ready;
  assign ll_push_sel = in_sel;

  assign out_open    = ~out_valid_q | out_ready;
  assign ll_pop      = rst_n & out_open & gnt_valid;
  assign ll_pop_sel  = gnt_idx;

  assign out_valid   = out_valid_q;
  assign out_sel     = out_sel_q;
  assign out_data    = out_data_q;

  rr_arbiter #(
    .N     (NUM_LISTS),
    .IDX_W (SEL_WIDTH)
  ) u_rr_arbiter (
    .req_i       (~ll_empty),
    .last_i      (rr_ptr_q),
    .gnt_valid_o (gnt_valid),
    .gnt_idx_o   (gnt_idx)
  );

  // Payload store; not reset. The pop path reads the pre-edge contents, so a
  // same-cycle write to the head slot cannot corrupt the word being dequeued.
  always_ff @(posedge clk) begin
    if (ll_push) begin
      data_mem_q[ll_free_ptr] <= in_data;
    end
  end

  // Output stage next state: load on pop, empty out when open with nothing queued, hold when stalled.
  always_comb begin
    out_valid_d = out_valid_q;
    out_sel_d   = out_sel_q;
    out_data_d  = out_data_q;
    rr_ptr_d    = rr_ptr_q;
    if (out_open) begin
      out_valid_d = gnt_valid;
      if (gnt_valid) begin
        out_sel_d  = gnt_idx;
        out_data_d = data_mem_q[ll_popped_head];
        rr_ptr_d   = gnt_idx;
      end
    end
  end

  // Output and arbitration registers; rr_ptr resets to the last list so list 0 is served first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_sel_q   <= '0;
      out_data_q  <= '0;
      rr_ptr_q    <= SEL_WIDTH'(NUM_LISTS - 1);
    end else begin
      out_valid_q <= out_valid_d;
      out_sel_q   <= out_sel_d;
      out_data_q  <= out_data_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

endmodule

// File: tb/tb_ll_rr_dequeue.sv
// Bench for ll_rr_dequeue: behavioural pointer manager, per-list scoreboard and round-robin reference.
module tb_ll_rr_dequeue;
  import ll_rr_dequeue_pkg::*;

  localparam int NE = DEF_NUM_ELEMS;
  localparam int NL = DEF_NUM_LISTS;
  localparam int DW = DEF_DATA_WIDTH;
  localparam int PW = DEF_PTR_WIDTH;
  localparam int SW = DEF_SEL_WIDTH;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [SW-1:0] in_sel;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [SW-1:0] out_sel;
  logic [DW-1:0] out_data;
  logic          ll_push, ll_pop;
  logic [SW-1:0] ll_push_sel, ll_pop_sel;
  logic          ll_full        = 1'b0;
  logic [NL-1:0] ll_empty       = '1;
  logic [PW-1:0] ll_free_ptr    = '0;
  logic [PW-1:0] ll_popped_head = '0;

  int n_vec = 0;
  int n_err = 0;

  ll_rr_dequeue dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_sel         (in_sel),
    .in_data        (in_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_sel        (out_sel),
    .out_data       (out_data),
    .ll_push        (ll_push),
    .ll_pop         (ll_pop),
    .ll_push_sel    (ll_push_sel),
    .ll_pop_sel     (ll_pop_sel),
    .ll_full        (ll_full),
    .ll_empty       (ll_empty),
    .ll_free_ptr    (ll_free_ptr),
    .ll_popped_head (ll_popped_head)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Pointer manager model: a free-pointer queue and one pointer queue per list.
  int unsigned free_q[$];
  int unsigned lst0[$];
  int unsigned lst1[$];
  int unsigned p_pm;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      free_q.delete();
      lst0.delete();
      lst1.delete();
      for (int i = 0; i < NE; i++) free_q.push_back(i);
    end else begin
      if (ll_push && free_q.size() > 0) begin
        p_pm = free_q.pop_front();
        if (ll_push_sel == 0) lst0.push_back(p_pm); else lst1.push_back(p_pm);
      end
      if (ll_pop) begin
        if (ll_pop_sel == 0 && lst0.size() > 0) free_q.push_back(lst0.pop_front());
        if (ll_pop_sel == 1 && lst1.size() > 0) free_q.push_back(lst1.pop_front());
      end
    end
    ll_full        <= (free_q.size() == 0);
    ll_free_ptr    <= (free_q.size() > 0) ? PW'(free_q[0]) : '0;
    ll_empty       <= {(lst1.size() == 0), (lst0.size() == 0)};
    ll_popped_head <= '0;
  end

  // Head pointer follows the list the DUT is about to pop.
  always @(negedge clk) begin
    if (ll_pop_sel == 0 && lst0.size() > 0) ll_popped_head = PW'(lst0[0]);
    else if (ll_pop_sel == 1 && lst1.size() > 0) ll_popped_head = PW'(lst1[0]);
  end

  // Reference: scoreboard queues per list, output register and rr pointer model.
  logic [DW-1:0] exp0[$];
  logic [DW-1:0] exp1[$];
  logic          ov_m;
  logic [SW-1:0] os_m;
  logic [DW-1:0] od_m;
  int            rr_m;
  logic          exp_push, open_m, g_ok, exp_pop;
  int            g_sel, idx_m;
  int            n_egress = 0;
  int            sel_log[$];

  always @(negedge clk) begin
    #1;
    if (!rst_n) begin
      chk("rst_out_valid", out_valid, 0);
      chk("rst_ll_push", ll_push, 0);
      chk("rst_ll_pop", ll_pop, 0);
      chk("rst_in_ready", in_ready, 0);
      ov_m = 1'b0; os_m = '0; od_m = '0; rr_m = NL - 1;
      exp0.delete(); exp1.delete();
    end else begin
      chk("in_ready", in_ready, !ll_full);
      exp_push = in_valid && !ll_full;
      chk("ll_push", ll_push, exp_push);
      if (exp_push) begin
        chk("ll_push_sel", ll_push_sel, in_sel);
        if (in_sel == 0) exp0.push_back(in_data); else exp1.push_back(in_data);
      end
      chk("out_valid", out_valid, ov_m);
      if (ov_m) begin
        chk("out_sel", out_sel, os_m);
        chk("out_data", out_data, od_m);
      end
      if (out_valid && out_ready) begin
        n_egress++;
        sel_log.push_back(int'(out_sel));
      end
      open_m = !ov_m || out_ready;
      g_ok = 1'b0; g_sel = 0;
      for (int i = 1; i <= NL; i++) begin
        idx_m = (rr_m + i) % NL;
        if (!g_ok && !ll_empty[idx_m]) begin g_ok = 1'b1; g_sel = idx_m; end
      end
      exp_pop = open_m && g_ok;
      chk("ll_pop", ll_pop, exp_pop);
      if (exp_pop) begin
        chk("ll_pop_sel", ll_pop_sel, g_sel);
        if (g_sel == 0) begin
          if (exp0.size() > 0) od_m = exp0.pop_front(); else chk("sb_list0_depth", exp0.size(), 1);
        end else begin
          if (exp1.size() > 0) od_m = exp1.pop_front(); else chk("sb_list1_depth", exp1.size(), 1);
        end
        os_m = SW'(g_sel); rr_m = g_sel; ov_m = 1'b1;
      end else if (open_m) begin
        ov_m = 1'b0;
      end
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic push(input int s, input logic [DW-1:0] d);
    int t;
    in_valid = 1'b1; in_sel = SW'(s); in_data = d; t = 0;
    while (!in_ready && t < 50) begin cyc(); t++; end
    if (t >= 50) chk("push_ready_wait", in_ready, 1);
    cyc();
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((out_valid || ll_empty != '1) && t < 100) begin cyc(); t++; end
    if (t >= 100) chk("idle_wait", out_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, e0;
    rst_n = 1'b0; in_valid = 1'b0; in_sel = '0; in_data = '0; out_ready = 1'b0;
    cyc(3);
    chk("rst_out_sel", out_sel, 0);
    chk("rst_out_data", out_data, 0);
    rst_n = 1'b1;
    cyc(2);

    // Two words to list 0, egress open: latency 2 from first accept, FIFO order.
    out_ready = 1'b1;
    in_valid = 1'b1; in_sel = 0; in_data = 8'hA1;
    cyc();
    chk("lat1_out_valid", out_valid, 0);
    in_data = 8'hA2;
    cyc();
    in_valid = 1'b0;
    chk("lat2_out_valid", out_valid, 1);
    chk("lat2_out_data", out_data, 8'hA1);
    cyc();
    chk("a2_out_data", out_data, 8'hA2);
    chk("a2_out_sel", out_sel, 0);
    cyc();
    chk("a_drained", out_valid, 0);

    // Two words on each list, then release the egress: strict alternation.
    out_ready = 1'b0;
    push(0, 8'hB0); push(0, 8'hB1); push(1, 8'hC0); push(1, 8'hC1);
    cyc(2);
    sel_log.delete();
    out_ready = 1'b1;
    t = 0;
    while (sel_log.size() < 4 && t < 20) begin cyc(); t++; end
    chk("rr_count", sel_log.size(), 4);
    if (sel_log.size() >= 4) begin
      chk("rr_seq0", sel_log[0], 0);
      chk("rr_seq1", sel_log[1], 1);
      chk("rr_seq2", sel_log[2], 0);
      chk("rr_seq3", sel_log[3], 1);
    end
    wait_idle();

    // Output register occupied and stalled, then four words fill the buffer.
    out_ready = 1'b0;
    push(0, 8'hD0);
    cyc(2);
    push(1, 8'hE0); push(0, 8'hE1); push(1, 8'hE2); push(0, 8'hE3);
    chk("full_in_ready", in_ready, 0);
    in_valid = 1'b1; in_sel = 0; in_data = 8'hE4;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("full_no_push", ll_push, 0);
      chk("stall_no_pop", ll_pop, 0);
      chk("stall_out_data", out_data, 8'hD0);
      chk("stall_out_sel", out_sel, 0);
    end
    out_ready = 1'b1;
    t = 0;
    while (!in_ready && t < 20) begin cyc(); t++; end
    chk("e4_in_ready", in_ready, 1);
    cyc();
    in_valid = 1'b0;
    wait_idle();

    // Push list 0 every cycle with egress open: one egress per cycle.
    e0 = n_egress;
    in_valid = 1'b1; in_sel = 0;
    for (int i = 0; i < 8; i++) begin
      in_data = DW'(8'hF0 + i);
      cyc();
    end
    in_valid = 1'b0;
    cyc(3);
    chk("stream_egress", n_egress - e0, 8);
    wait_idle();

    // Random mix of pushes and back-pressure.
    for (int i = 0; i < 300; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_sel    = SW'($urandom_range(0, NL - 1));
      in_data   = DW'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      cyc();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    wait_idle();

    // Reset with a word sitting in the output register.
    out_ready = 1'b0;
    push(1, 8'h55);
    cyc(2);
    chk("pre_rst_out_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", out_valid, 0);
    chk("async_rst_out_sel", out_sel, 0);
    chk("async_rst_out_data", out_data, 0);
    cyc(2);
    rst_n = 1'b1;
    cyc();
    out_ready = 1'b1;
    in_valid = 1'b1; in_sel = 0; in_data = 8'h66;
    cyc();
    in_valid = 1'b0;
    t = 0;
    while (!ll_pop && t < 10) begin cyc(); t++; end
    chk("post_rst_pop", ll_pop, 1);
    chk("post_rst_pop_sel", ll_pop_sel, 0);
    wait_idle();
    cyc(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
